vx_dispatch_arb: RTL and testbench

Round-robin arbiter that shares one execution-unit dispatch port among `NUM_REQS` requesting issue slots. Each requester presents a valid/ready dispatch packet. The block grants one per cycle, registers the winner into a single output stage, and tags it with the source index so the unit can route its commit back. It sits between the dispatch elastic buffers and a shared functional unit (for example, a single SFU serving all issue slots).

---
 rtl/vx_dispatch_arb.sv | 118 +++++++++++
 tb/tb_vx_dispatch_arb.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/vx_dispatch_arb.sv
// rtl/vx_dispatch_arb.sv - round-robin arbiter sharing one registered dispatch port among NUM_REQS requesters.
// Optional per-requester stall counters are compiled in with VX_DISPATCH_ARB_PERF_EN.
module vx_dispatch_arb #(
   parameter int NUM_REQS = 4,
   parameter int DATAW    = 64,
   parameter int PERF_W   = 16,
   parameter int SEL_W    = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_REQS-1:0]       valid_in,
   input  logic [NUM_REQS*DATAW-1:0] data_in,
   output logic [NUM_REQS-1:0]       ready_in,
   output logic                      valid_out,
   output logic [DATAW-1:0]          data_out,
   output logic [SEL_W-1:0]          sel_out,
   input  logic                      ready_out
`ifdef VX_DISPATCH_ARB_PERF_EN
   ,
   output logic [NUM_REQS*PERF_W-1:0] perf_stalls
`endif
);

   logic [SEL_W-1:0] ptr;
   logic [SEL_W-1:0] grant;
   logic [SEL_W-1:0] hi_idx;
   logic [SEL_W-1:0] lo_idx;
   logic [SEL_W-1:0] ptr_next;
   logic             grant_valid;
   logic             hi_valid;
   logic             stage_en;
   logic             fire;
   logic [DATAW-1:0] grant_data;

   // Lowest valid index at or above ptr wins; otherwise wrap to the lowest valid index overall.
   always_comb begin
      hi_valid    = 1'b0;
      hi_idx      = '0;
      grant_valid = 1'b0;
      lo_idx      = '0;
      for (int i = NUM_REQS - 1; i >= 0; i--) begin
         if (valid_in[i]) begin
            grant_valid = 1'b1;
            lo_idx      = SEL_W'(i);
            if (i >= int'(ptr)) begin
               hi_valid = 1'b1;
               hi_idx   = SEL_W'(i);
            end
         end
      end
      grant = hi_valid ? hi_idx : lo_idx;
   end

   always_comb begin
      grant_data = '0;
      for (int i = 0; i < NUM_REQS; i++) begin
         if (grant == SEL_W'(i)) begin
            grant_data = data_in[i*DATAW +: DATAW];
         end
      end
   end

   assign stage_en = ~valid_out | ready_out;
   assign fire     = reset & stage_en & grant_valid;
   assign ptr_next = (grant == SEL_W'(NUM_REQS - 1)) ? '0 : grant + SEL_W'(1);

   always_comb begin
      ready_in = '0;
      for (int i = 0; i < NUM_REQS; i++) begin
         ready_in[i] = fire & (grant == SEL_W'(i));
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ptr       <= '0;
         valid_out <= 1'b0;
         data_out  <= '0;
         sel_out   <= '0;
      end else begin
         if (fire) begin
            valid_out <= 1'b1;
            data_out  <= grant_data;
            sel_out   <= grant;
            ptr       <= ptr_next;
         end else if (ready_out) begin
            valid_out <= 1'b0;
         end
      end
   end

`ifdef VX_DISPATCH_ARB_PERF_EN
   logic [PERF_W-1:0] stall_cnt [NUM_REQS];

   // Saturating: a stuck requester pins its counter at all-ones instead of wrapping.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NUM_REQS; i++) begin
            stall_cnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_REQS; i++) begin
            if (valid_in[i] && !ready_in[i] && (stall_cnt[i] != '1)) begin
               stall_cnt[i] <= stall_cnt[i] + PERF_W'(1);
            end
         end
      end
   end

   always_comb begin
      perf_stalls = '0;
      for (int i = 0; i < NUM_REQS; i++) begin
         perf_stalls[i*PERF_W +: PERF_W] = stall_cnt[i];
      end
   end
`endif

endmodule

// File: tb/tb_vx_dispatch_arb.sv
// tb/tb_vx_dispatch_arb.sv - directed bench for vx_dispatch_arb (4-requester and 1-requester instances).
module tb_vx_dispatch_arb;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  valid_in;
   logic [63:0] data_in;
   logic [3:0]  ready_in;
   logic        valid_out;
   logic [15:0] data_out;
   logic [1:0]  sel_out;
   logic        ready_out;
`ifdef VX_DISPATCH_ARB_PERF_EN
   logic [15:0] perf_stalls;
`endif

   logic        v1;
   logic [7:0]  d1;
   logic        r1;
   logic        vo1;
   logic [7:0]  do1;
   logic [0:0]  so1;
   logic        ro1;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   vx_dispatch_arb #(.NUM_REQS(4), .DATAW(16), .PERF_W(4)) u_dut (
      .clk       (clk),
      .reset     (reset),
      .valid_in  (valid_in),
      .data_in   (data_in),
      .ready_in  (ready_in),
      .valid_out (valid_out),
      .data_out  (data_out),
      .sel_out   (sel_out),
      .ready_out (ready_out)
`ifdef VX_DISPATCH_ARB_PERF_EN
      ,
      .perf_stalls (perf_stalls)
`endif
   );

   vx_dispatch_arb #(.NUM_REQS(1), .DATAW(8), .PERF_W(4)) u_one (
      .clk       (clk),
      .reset     (reset),
      .valid_in  (v1),
      .data_in   (d1),
      .ready_in  (r1),
      .valid_out (vo1),
      .data_out  (do1),
      .sel_out   (so1),
      .ready_out (ro1)
`ifdef VX_DISPATCH_ARB_PERF_EN
      ,
      .perf_stalls ()
`endif
   );

   task automatic set_data(input logic [15:0] base);
      for (int i = 0; i < 4; i++) data_in[i*16 +: 16] = base + 16'(i);
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      reset = 1'b0; valid_in = 4'b1111; set_data(16'h0010); ready_out = 1'b1;
      v1 = 1'b1; d1 = 8'h55; ro1 = 1'b1;
      step(); step();
      total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", valid_out); end
      total++; if (data_out !== 16'h0) begin bad++; $display("FAIL reset_data got=%h exp=0000", data_out); end
      total++; if (sel_out !== 2'd0) begin bad++; $display("FAIL reset_sel got=%0d exp=0", sel_out); end
      total++; if (ready_in !== 4'b0000) begin bad++; $display("FAIL reset_ready got=%b exp=0000", ready_in); end
      total++; if (r1 !== 1'b0) begin bad++; $display("FAIL reset_ready_one got=%b exp=0", r1); end
      reset = 1'b1; valid_in = 4'b0000; v1 = 1'b0;
      step();
      total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL idle_valid got=%b exp=0", valid_out); end
   endtask

   task automatic test_round_robin;
      logic [3:0] exp_rdy;
      valid_in = 4'b1111; set_data(16'h0100); ready_out = 1'b1;
      #1;
      for (int k = 0; k < 8; k++) begin
         exp_rdy = 4'b0001 << (k % 4);
         total++; if (ready_in !== exp_rdy) begin bad++; $display("FAIL rr_ready[%0d] got=%b exp=%b", k, ready_in, exp_rdy); end
         step();
         total++; if (valid_out !== 1'b1 || sel_out !== 2'(k % 4) || data_out !== 16'h0100 + 16'(k % 4)) begin
            bad++; $display("FAIL rr_out[%0d] got v=%b sel=%0d data=%h exp v=1 sel=%0d data=%h",
                            k, valid_out, sel_out, data_out, k % 4, 16'h0100 + 16'(k % 4));
         end
      end
      valid_in = 4'b0000;
      step();
      total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL rr_drain got=%b exp=0", valid_out); end
   endtask

   task automatic test_wrap;
      set_data(16'h0400); ready_out = 1'b1;
      valid_in = 4'b0100; #1;
      total++; if (ready_in !== 4'b0100) begin bad++; $display("FAIL wrap_ready2 got=%b exp=0100", ready_in); end
      step();
      total++; if (sel_out !== 2'd2 || data_out !== 16'h0402) begin bad++; $display("FAIL wrap_sel2 got=%0d/%h exp=2/0402", sel_out, data_out); end
      valid_in = 4'b1001; #1;
      total++; if (ready_in !== 4'b1000) begin bad++; $display("FAIL wrap_ready3 got=%b exp=1000", ready_in); end
      step();
      total++; if (sel_out !== 2'd3 || data_out !== 16'h0403) begin bad++; $display("FAIL wrap_sel3 got=%0d/%h exp=3/0403", sel_out, data_out); end
      total++; if (ready_in !== 4'b0001) begin bad++; $display("FAIL wrap_ready0 got=%b exp=0001", ready_in); end
      step();
      total++; if (sel_out !== 2'd0 || data_out !== 16'h0400) begin bad++; $display("FAIL wrap_sel0 got=%0d/%h exp=0/0400", sel_out, data_out); end
      valid_in = 4'b0000;
      step();
   endtask

   task automatic test_stall;
      valid_in = 4'b0010; set_data(16'h0110); ready_out = 1'b1; #1;
      total++; if (ready_in !== 4'b0010) begin bad++; $display("FAIL stall_first_ready got=%b exp=0010", ready_in); end
      step();
      total++; if (valid_out !== 1'b1 || data_out !== 16'h0111 || sel_out !== 2'd1) begin
         bad++; $display("FAIL stall_load got v=%b data=%h sel=%0d exp v=1 data=0111 sel=1", valid_out, data_out, sel_out);
      end
      ready_out = 1'b0; set_data(16'h0220); #1;
      for (int k = 0; k < 5; k++) begin
         total++; if (ready_in !== 4'b0000 || valid_out !== 1'b1 || data_out !== 16'h0111 || sel_out !== 2'd1) begin
            bad++; $display("FAIL stall_hold[%0d] got rdy=%b v=%b data=%h sel=%0d exp rdy=0000 v=1 data=0111 sel=1",
                            k, ready_in, valid_out, data_out, sel_out);
         end
         step();
      end
      ready_out = 1'b1; #1;
      total++; if (ready_in !== 4'b0010) begin bad++; $display("FAIL stall_release_ready got=%b exp=0010", ready_in); end
      step();
      total++; if (valid_out !== 1'b1 || data_out !== 16'h0221 || sel_out !== 2'd1) begin
         bad++; $display("FAIL stall_refill got v=%b data=%h sel=%0d exp v=1 data=0221 sel=1", valid_out, data_out, sel_out);
      end
      valid_in = 4'b0000;
      step();
      total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL stall_drain got=%b exp=0", valid_out); end
   endtask

   task automatic test_reset_mid;
      valid_in = 4'b0010; set_data(16'h0330); ready_out = 1'b1;
      step();
      total++; if (valid_out !== 1'b1 || data_out !== 16'h0331) begin bad++; $display("FAIL mid_load got v=%b data=%h exp v=1 data=0331", valid_out, data_out); end
      valid_in = 4'b1010; ready_out = 1'b0;
      #2 reset = 1'b0;
      #1;
      total++; if (valid_out !== 1'b0 || data_out !== 16'h0 || sel_out !== 2'd0) begin
         bad++; $display("FAIL mid_reset_out got v=%b data=%h sel=%0d exp v=0 data=0000 sel=0", valid_out, data_out, sel_out);
      end
      total++; if (ready_in !== 4'b0000) begin bad++; $display("FAIL mid_reset_ready got=%b exp=0000", ready_in); end
      step();
      reset = 1'b1; ready_out = 1'b1; #1;
      total++; if (ready_in !== 4'b0010) begin bad++; $display("FAIL mid_first_grant got=%b exp=0010", ready_in); end
      step();
      total++; if (sel_out !== 2'd1 || data_out !== 16'h0331) begin bad++; $display("FAIL mid_first_sel got=%0d/%h exp=1/0331", sel_out, data_out); end
      valid_in = 4'b0000;
      step();
   endtask

   task automatic test_back_to_back;
      logic [7:0] pk [3];
      pk[0] = 8'h0A; pk[1] = 8'h0B; pk[2] = 8'h0C;
      v1 = 1'b1; ro1 = 1'b1;
      for (int k = 0; k < 3; k++) begin
         d1 = pk[k]; #1;
         total++; if (r1 !== 1'b1) begin bad++; $display("FAIL b2b_ready[%0d] got=%b exp=1", k, r1); end
         step();
         total++; if (vo1 !== 1'b1 || do1 !== pk[k] || so1 !== 1'b0) begin
            bad++; $display("FAIL b2b_out[%0d] got v=%b data=%h sel=%0d exp v=1 data=%h sel=0", k, vo1, do1, so1, pk[k]);
         end
      end
      v1 = 1'b0;
      step();
      total++; if (vo1 !== 1'b0) begin bad++; $display("FAIL b2b_drain got=%b exp=0", vo1); end
   endtask

`ifdef VX_DISPATCH_ARB_PERF_EN
   task automatic test_perf;
      reset = 1'b0; step();
      reset = 1'b1; valid_in = 4'b0001; set_data(16'h0500); ready_out = 1'b0;
      step();
      total++; if (perf_stalls !== 16'h0000) begin bad++; $display("FAIL perf_start got=%h exp=0000", perf_stalls); end
      repeat (5) step();
      total++; if (perf_stalls !== 16'h0005) begin bad++; $display("FAIL perf_count got=%h exp=0005", perf_stalls); end
      repeat (15) step();
      total++; if (perf_stalls !== 16'h000F) begin bad++; $display("FAIL perf_saturate got=%h exp=000f", perf_stalls); end
      valid_in = 4'b0000; ready_out = 1'b1;
      step();
   endtask
`endif

   initial begin
      test_reset();
      test_round_robin();
      test_wrap();
      test_stall();
      test_reset_mid();
      test_back_to_back();
`ifdef VX_DISPATCH_ARB_PERF_EN
      test_perf();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
